// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet framer and cursor tracker.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    // Bit positions inside the packet header byte
    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XS    = 4;
    localparam int unsigned YS    = 5;
    localparam int unsigned XO    = 6;
    localparam int unsigned YO    = 7;

    localparam int unsigned TIMEOUT_CYC_DEF = 54000;
    localparam int unsigned DELTA_W         = 9;

    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } mouse_pkt_t;

    // 9-bit two's complement movement; an overflowed axis contributes nothing
    function automatic logic [DELTA_W-1:0] axis_delta(input logic sign,
                                                      input logic ovf,
                                                      input logic [7:0] mag);
        return ovf ? '0 : {sign, mag};
    endfunction

endpackage

// File: rtl/axis_accum_clamp.sv
// One cursor axis: adds (or subtracts) a signed delta and clamps to 0..RES-1.
module axis_accum_clamp
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned W      = 10,
    parameter int unsigned RES    = 640,
    parameter bit          INVERT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DELTA_W-1:0] delta,
    output logic [W-1:0]       pos
);

    localparam int unsigned SW = W + 2;
    localparam logic signed [SW-1:0] MAX_POS = SW'(RES - 1);

    logic signed [SW-1:0] pos_ext;
    logic signed [SW-1:0] delta_ext;
    logic signed [SW-1:0] sum;
    logic [W-1:0]         pos_nxt;

    assign pos_ext   = signed'({2'b00, pos});
    assign delta_ext = SW'(signed'(delta));

    // Wide signed sum so both underflow and overflow are visible before clamping
    always_comb begin
        sum     = INVERT ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
        pos_nxt = W'(sum);
        if (sum[SW-1]) begin
            pos_nxt = '0;
        end else if (sum > MAX_POS) begin
            pos_nxt = W'(RES - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= W'(RES / 2);
        end else if (en) begin
            pos <= pos_nxt;
        end
    end

endmodule

// File: rtl/ps2_mouse_cursor.sv
// Frames PS/2 stream-mode mouse bytes into packets and tracks a clamped cursor.
module ps2_mouse_cursor
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 10,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stream_en,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    input  logic           rx_error,
    output logic [X_W-1:0] cursor_x,
    output logic [Y_W-1:0] cursor_y,
    output logic           btn_left,
    output logic           btn_right,
    output logic           btn_middle,
    output logic           pkt_valid,
    output logic           sync_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state;
    mouse_pkt_t         pkt;
    logic [CNT_W-1:0]   to_cnt;
    logic               upd_en;
    logic [DELTA_W-1:0] dx;
    logic [DELTA_W-1:0] dy;

    assign dx     = axis_delta(pkt.b0[XS], pkt.b0[XO], pkt.b1);
    assign dy     = axis_delta(pkt.b0[YS], pkt.b0[YO], pkt.b2);
    assign upd_en = (state == UPDATE) && stream_en && !rx_error;

    // Packet framing FSM; priority is disable, then error, then byte, then timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_B0;
            pkt        <= '0;
            to_cnt     <= '0;
            btn_left   <= 1'b0;
            btn_right  <= 1'b0;
            btn_middle <= 1'b0;
            pkt_valid  <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (!stream_en) begin
                state  <= WAIT_B0;
                to_cnt <= '0;
            end else if (rx_error) begin
                state    <= WAIT_B0;
                to_cnt   <= '0;
                sync_err <= 1'b1;
            end else begin
                case (state)
                    WAIT_B0: begin
                        if (rx_valid) begin
                            if (rx_data[SYNC]) begin
                                pkt.b0 <= rx_data;
                                to_cnt <= '0;
                                state  <= WAIT_B1;
                            end else begin
                                sync_err <= 1'b1;
                            end
                        end
                    end
                    WAIT_B1, WAIT_B2: begin
                        if (rx_valid) begin
                            to_cnt <= '0;
                            if (state == WAIT_B1) begin
                                pkt.b1 <= rx_data;
                                state  <= WAIT_B2;
                            end else begin
                                pkt.b2 <= rx_data;
                                state  <= UPDATE;
                            end
                        end else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                            to_cnt   <= '0;
                            sync_err <= 1'b1;
                            state    <= WAIT_B0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    UPDATE: begin
                        btn_left   <= pkt.b0[BTN_L];
                        btn_right  <= pkt.b0[BTN_R];
                        btn_middle <= pkt.b0[BTN_M];
                        pkt_valid  <= 1'b1;
                        state      <= WAIT_B0;
                    end
                    default: state <= WAIT_B0;
                endcase
            end
        end
    end

    axis_accum_clamp #(
        .W      (X_W),
        .RES    (H_RES),
        .INVERT (1'b0)
    ) u_axis_x (
        .clk   (clk),
        .rst   (rst),
        .en    (upd_en),
        .delta (dx),
        .pos   (cursor_x)
    );

    // Screen Y grows downward while mouse Y grows upward
    axis_accum_clamp #(
        .W      (Y_W),
        .RES    (V_RES),
        .INVERT (1'b1)
    ) u_axis_y (
        .clk   (clk),
        .rst   (rst),
        .en    (upd_en),
        .delta (dy),
        .pos   (cursor_y)
    );

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Scoreboard bench for ps2_mouse_cursor: directed packets, queued expectations, pulse monitor.
module tb_ps2_mouse_cursor;

    logic       clk;
    logic       rst;
    logic       stream_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic       btn_left;
    logic       btn_right;
    logic       btn_middle;
    logic       pkt_valid;
    logic       sync_err;

    typedef struct {
        bit         is_pkt;
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    ps2_mouse_cursor dut (
        .clk        (clk),
        .rst        (rst),
        .stream_en  (stream_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_middle (btn_middle),
        .pkt_valid  (pkt_valid),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && (pkt_valid || sync_err)) begin
            chk("expect_queued", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("pkt_valid", int'(pkt_valid), int'(mon_e.is_pkt));
                chk("sync_err", int'(sync_err), int'(!mon_e.is_pkt));
                if (mon_e.cyc >= 0) chk("pulse_cycle", cyc, mon_e.cyc);
                if (mon_e.is_pkt) begin
                    chk("cursor_x", int'(cursor_x), int'(mon_e.x));
                    chk("cursor_y", int'(cursor_y), int'(mon_e.y));
                    chk("buttons", int'({btn_middle, btn_right, btn_left}), int'(mon_e.btn));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic err);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_error = err;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic push_sync(input int at_cyc);
        exp_t e;
        e.is_pkt = 1'b0;
        e.cyc    = at_cyc;
        e.x      = '0;
        e.y      = '0;
        e.btn    = '0;
        q.push_back(e);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int x, input int y, input logic [2:0] btn);
        exp_t e;
        send(b0, 1'b0);
        send(b1, 1'b0);
        send(b2, 1'b0);
        e.is_pkt = 1'b1;
        e.cyc    = last_cyc + 1;
        e.x      = 10'(x);
        e.y      = 10'(y);
        e.btn    = btn;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        repeat (6) @(posedge clk);
        #1;
        chk(name, q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cursor_x", int'(cursor_x), 320);
        chk("rst_cursor_y", int'(cursor_y), 240);
        chk("rst_buttons", int'({btn_middle, btn_right, btn_left}), 0);
        chk("rst_pulses", int'({pkt_valid, sync_err}), 0);
    endtask

    initial begin
        rst       = 1'b1;
        stream_en = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rx_error  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cursor_x", int'(cursor_x), 320);
        chk("rst_cursor_y", int'(cursor_y), 240);
        chk("rst_buttons", int'({btn_middle, btn_right, btn_left}), 0);
        chk("rst_pulses", int'({pkt_valid, sync_err}), 0);
        rst       = 1'b0;
        stream_en = 1'b1;

        // dy=+253 pushes Y past the top edge
        send_pkt(8'h09, 8'h05, 8'hFD, 325, 0, 3'b001);
        send_pkt(8'h08, 8'h0A, 8'h08, 335, 0, 3'b000);
        drain("drain_basic");

        // Header without sync bit is dropped
        do_reset();
        send(8'h00, 1'b0);
        push_sync(last_cyc);
        send_pkt(8'h08, 8'h10, 8'h00, 336, 240, 3'b000);
        drain("drain_badhdr");

        // Inter-byte gap beyond the timeout discards the partial packet
        do_reset();
        send(8'h08, 1'b0);
        send(8'h05, 1'b0);
        push_sync(-1);
        repeat (54100) @(posedge clk);
        send_pkt(8'h08, 8'h05, 8'h00, 325, 240, 3'b000);
        drain("drain_timeout");

        // X overflow ignores dx, then saturate at the right edge
        do_reset();
        send_pkt(8'h58, 8'h80, 8'h00, 320, 240, 3'b000);
        send_pkt(8'h08, 8'h7F, 8'h00, 447, 240, 3'b000);
        send_pkt(8'h08, 8'h7F, 8'h00, 574, 240, 3'b000);
        send_pkt(8'h08, 8'h7F, 8'h00, 639, 240, 3'b000);
        drain("drain_clamp");

        // rx_error with byte1 aborts; next packet moves dx=-1 from the edge
        send(8'h08, 1'b0);
        send(8'h05, 1'b1);
        push_sync(last_cyc);
        send_pkt(8'h18, 8'hFF, 8'h00, 638, 240, 3'b000);
        drain("drain_rxerr");

        // Disabled stream holds everything
        @(posedge clk); #1;
        stream_en = 1'b0;
        send(8'h09, 1'b0);
        send(8'h05, 1'b0);
        send(8'h05, 1'b0);
        drain("drain_disabled");
        chk("hold_cursor_x", int'(cursor_x), 638);
        chk("hold_cursor_y", int'(cursor_y), 240);
        chk("hold_buttons", int'({btn_middle, btn_right, btn_left}), 0);
        stream_en = 1'b1;
        send_pkt(8'h08, 8'h00, 8'h01, 638, 239, 3'b000);
        send_pkt(8'h2E, 8'h00, 8'hFF, 638, 240, 3'b110);
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
